riscv_if_stage: RTL and testbench
=================================

// Module: riscv_if_stage
// PURPOSE
// - Instruction-fetch stage of the 5-stage riscv_core: owns the PC, drives the instruction-memory
//   address, and registers fetched words into the IF/ID pipeline register consumed by decode.
// - Honours load-use stalls from the hazard unit and branch/jump redirects from EX.
//   A redirect squashes the wrong-path word into a NOP bubble.
// - Instruction memory is combinational: instr_data is valid in the same cycle pc is presented.
// PARAMETERS
// - RESET_PC   32'h0000_0000   PC value loaded on reset; bits [1:0] must be 0
// - NOP_INSTR  32'h0000_0013   bubble encoding (addi x0,x0,0)
// PORTS
// - clk                  in   1   single clock, all state on posedge
// - rst_n                in   1   asynchronous active-low reset
// - pc                   out  32  current fetch address to instruction memory
// - instr_read           out  1   fetch strobe; 1 whenever out of reset
// - instr_data           in   32  instruction word at pc, same cycle
// - stall                in   1   hazard unit: hold PC and IF/ID
// - redirect_valid       in   1   EX: taken branch/jump this cycle
// - redirect_target      in   32  EX: new PC
// - id_valid             out  1   IF/ID holds a real instruction
// - id_pc                out  32  PC of id_instr
// - id_pc_plus4          out  32  id_pc + 4, used for the jal/jalr link value
// - id_instr             out  32  instruction to decode (NOP_INSTR when !id_valid)
// - redirect_misaligned  out  1   one-cycle pulse: accepted redirect had target[1:0] != 0
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - pc=RESET_PC; instr_read=0
//   - id_valid=0, id_pc=0, id_pc_plus4=0, id_instr=NOP_INSTR
//   - redirect_misaligned=0
// - instr_read is a registered flag: 0 in reset, 1 from the first posedge after rst_n rises.
//   - Before that edge, IF/ID is not loaded and pc holds RESET_PC.
// - Each posedge, priority (highest first):
//   - redirect_valid: pc <= {redirect_target[31:2],2'b00}; IF/ID <= bubble
//     (id_valid=0, id_instr=NOP_INSTR, id_pc/id_pc_plus4 unchanged).
//     Applies regardless of stall, because the redirect kills the stalled wrong-path word.
//     redirect_misaligned <= |redirect_target[1:0].
//   - stall: pc, id_* hold; redirect_misaligned <= 0.
//   - else: pc <= pc+4; id_pc <= pc; id_pc_plus4 <= pc+4; id_instr <= instr_data; id_valid <= 1.
// - Latency: word at pc appears on id_instr exactly 1 cycle later. Redirect penalty: 1 bubble
//   from this stage (EX-resolved branches also require the ID flush, done in the core).
// - Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
// - A stall held for N cycles leaves all outputs constant for N cycles; no word is lost or duplicated.
// - Reset mid-operation: all state returns to reset values asynchronously; the in-flight IF/ID word is discarded.
// - Internal state machine: BOOT (instr_read=0) -> RUN on first clock after rst_n=1; RUN only exits via reset.
// STRUCTURE
// - riscv_pkg owns these shared definitions:
//   - NOP_INSTR and RESET_PC constants
//   - if_id_t struct {valid, pc, pc_plus4, instr}, reused by the ID stage and the hazard unit
// - One sub-module, riscv_pc_gen, holds the PC register, the pc+4 adder and the next-PC
//   priority mux.
// - The IF/ID register, BOOT/RUN flag and misaligned pulse live in riscv_if_stage.
// TESTING
// - Straight-line fetch. Program: [0]=00500093, [1]=00300113, [2]=002081b3, [3]=00a00213.
//   -> after reset, pc is 0,4,8,C on consecutive cycles.
//   -> id_instr lags pc by 1 cycle, with id_valid=1 and id_pc_plus4=id_pc+4.
// - Stall: assert stall for 3 cycles while pc=8.
//   -> pc=8 and id_instr=00300113 are held for 3 cycles.
//   -> 002081b3 appears next, with no duplicate and no loss.
// - Redirect: at pc=C, redirect_valid=1, target=0x40.
//   -> next cycle pc=0x40 and id_valid=0, id_instr=00000013.
//   -> following cycle id_instr=mem[0x40], id_pc=0x40.
// - Redirect during stall, plus misalignment: stall=1 and redirect_valid=1 with target=0x42.
//   -> pc=0x40, bubble in ID, redirect_misaligned=1 for exactly 1 cycle.
// - Wrap: force pc to 0xFFFFFFFC via redirect.
//   -> next fetch pc=0x0, id_pc=0xFFFFFFFC, id_pc_plus4=0x0.
// - Reset mid-run: drop rst_n for 1 cycle while id_valid=1.
//   -> outputs immediately return to reset values, instr_read=0, then the fetch sequence restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the riscv_core pipeline.
// Holds the reset PC and bubble encoding, the IF/ID pipeline register layout (also consumed
// by the ID stage and hazard unit), the fetch-stage BOOT/RUN state type, and a word-align helper.
package riscv_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } if_id_t;

  typedef enum logic {
    StBoot,
    StRun
  } if_state_e;

  // Force a byte address onto a 4-byte boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/riscv_if_stage_if.sv
// Bus bundle around the instruction-fetch stage.
// Signals: pc/instr_read/instr_data (instruction memory), stall (hazard unit),
// redirect_valid/redirect_target (EX), id_* (IF/ID register to decode),
// redirect_misaligned (pulse on a misaligned accepted redirect).
// master: the fetch stage itself; slave: the surrounding core / environment.
interface riscv_if_stage_if;

  logic [31:0] pc;
  logic        instr_read;
  logic [31:0] instr_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic        redirect_misaligned;

  modport master (
    output pc, instr_read, id_valid, id_pc, id_pc_plus4, id_instr, redirect_misaligned,
    input  instr_data, stall, redirect_valid, redirect_target
  );

  modport slave (
    input  pc, instr_read, id_valid, id_pc, id_pc_plus4, id_instr, redirect_misaligned,
    output instr_data, stall, redirect_valid, redirect_target
  );

endinterface

// File: rtl/riscv_pc_gen.sv
// Program counter generator: PC register, pc+4 adder and next-PC priority mux.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_run               fetch enabled (PC frozen while booting)
//   i_stall             hold PC
//   i_redirect_valid    load redirect target (wins over stall)
//   i_redirect_target   new PC, low two bits dropped
//   o_pc                current fetch address
//   o_pc_plus4          o_pc + 4, modulo 2^32
module riscv_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000  // low two bits must be zero
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_run,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4
);
  import riscv_pkg::*;

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;  // wraps silently at the top of the address space

  always_comb begin
    w_pc_next = r_pc;
    if (i_run) begin
      if (i_redirect_valid) begin
        w_pc_next = align_word(i_redirect_target);
      end else if (!i_stall) begin
        w_pc_next = w_pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/riscv_if_stage.sv
// Instruction-fetch stage of the 5-stage riscv_core.
// Presents pc to a combinational instruction memory and registers the returned word into the
// IF/ID register. A redirect from EX overrides a stall and turns IF/ID into a bubble.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          riscv_if_stage_if.master: imem address/strobe/data, stall, redirect,
//                IF/ID outputs and the redirect_misaligned pulse
module riscv_if_stage #(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input logic              clk,
  input logic              rst_n,
  riscv_if_stage_if.master bus
);
  import riscv_pkg::*;

  if_state_e   r_state;
  if_state_e   w_state_next;
  logic        w_run;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  if_id_t      r_if_id;
  if_id_t      w_if_id_next;
  logic        r_misaligned;
  logic        w_misaligned_next;

  riscv_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_run             (w_run),
    .i_stall           (bus.stall),
    .i_redirect_valid  (bus.redirect_valid),
    .i_redirect_target (bus.redirect_target),
    .o_pc              (w_pc),
    .o_pc_plus4        (w_pc_plus4)
  );

  // BOOT lasts exactly one clock after reset release; RUN is left only through reset.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StBoot:  w_state_next = StRun;
      StRun:   w_state_next = StRun;
      default: w_state_next = StBoot;
    endcase
  end

  assign w_run = (r_state == StRun);

  always_comb begin
    w_if_id_next      = r_if_id;
    w_misaligned_next = 1'b0;
    if (w_run) begin
      if (bus.redirect_valid) begin
        // Kill the wrong-path word; id_pc/id_pc_plus4 keep their old values.
        w_if_id_next.valid = 1'b0;
        w_if_id_next.instr = NOP_INSTR;
        w_misaligned_next  = |bus.redirect_target[1:0];
      end else if (!bus.stall) begin
        w_if_id_next.valid    = 1'b1;
        w_if_id_next.pc       = w_pc;
        w_if_id_next.pc_plus4 = w_pc_plus4;
        w_if_id_next.instr    = bus.instr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state               <= StBoot;
      r_if_id.valid         <= 1'b0;
      r_if_id.pc            <= 32'h0;
      r_if_id.pc_plus4      <= 32'h0;
      r_if_id.instr         <= NOP_INSTR;
      r_misaligned          <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_if_id      <= w_if_id_next;
      r_misaligned <= w_misaligned_next;
    end
  end

  assign bus.pc                  = w_pc;
  assign bus.instr_read          = w_run;
  assign bus.id_valid            = r_if_id.valid;
  assign bus.id_pc               = r_if_id.pc;
  assign bus.id_pc_plus4         = r_if_id.pc_plus4;
  assign bus.id_instr            = r_if_id.instr;
  assign bus.redirect_misaligned = r_misaligned;

endmodule

// File: tb/tb_riscv_if_stage.sv
// Self-checking bench for riscv_if_stage: a reference model pushes the expected post-edge
// output snapshot into a scoreboard queue as each cycle's stimulus is driven; each scenario
// task pops and compares it after the edge, plus spot checks against fixed program values.
module tb_riscv_if_stage;
  import riscv_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic        rd;
    logic        v;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic [31:0] instr;
    logic        mis;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_if_stage_if bus();

  riscv_if_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:1023];
  assign bus.instr_data = mem[bus.pc[11:2]];

  obs_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
  logic        m_run, m_v, m_mis;

  localparam obs_t RESET_OBS = {32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0013, 1'b0};

  function automatic obs_t sample();
    return {bus.pc, bus.instr_read, bus.id_valid, bus.id_pc, bus.id_pc_plus4, bus.id_instr,
            bus.redirect_misaligned};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_run = 1'b0; m_v = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0;
    m_instr = 32'h0000_0013; m_mis = 1'b0;
  endtask

  // Advance the model, queue its expectation, drive one clock of stimulus.
  task automatic step(input logic st, input logic rv, input logic [31:0] rt);
    if (!m_run) begin
      m_run = 1'b1;
    end else if (rv) begin
      m_pc    = {rt[31:2], 2'b00};
      m_v     = 1'b0;
      m_instr = 32'h0000_0013;
      m_mis   = |rt[1:0];
    end else if (st) begin
      m_mis = 1'b0;
    end else begin
      m_v     = 1'b1;
      m_ipc   = m_pc;
      m_ipc4  = m_pc + 32'd4;
      m_instr = mem[m_pc[11:2]];
      m_pc    = m_pc + 32'd4;
      m_mis   = 1'b0;
    end
    sb.push_back({m_pc, m_run, m_v, m_ipc, m_ipc4, m_instr, m_mis});
    bus.stall           = st;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    @(posedge clk);
    #1;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o, e;
    repeat (2) @(negedge clk);
    o = sample();
    n_vec++;
    if (o !== RESET_OBS) begin
      n_err++;
      $display("FAIL reset_state: got %h required %h", o, RESET_OBS);
    end
    model_reset();
    rst_n = 1'b1;  // released at negedge, away from the active edge
    step(1'b0, 1'b0, 32'h0);
    e = sb.pop_front();
    o = sample();
    n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL boot: got %h required %h", o, e);
    end
    n_vec++;
    if (bus.instr_read !== 1'b1 || bus.pc !== 32'h0 || bus.id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL boot_run: instr_read=%b pc=%h id_valid=%b required 1/0/0",
               bus.instr_read, bus.pc, bus.id_valid);
    end
  endtask

  task automatic test_fetch();
    obs_t o, e;
    logic [31:0] want [2];
    want[0] = 32'h0050_0093;
    want[1] = 32'h0030_0113;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 32'h0);
      e = sb.pop_front();
      o = sample();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL fetch[%0d]: got %h required %h", i, o, e);
      end
      n_vec++;
      if (bus.pc !== 32'(4 * (i + 1)) || bus.id_instr !== want[i] || bus.id_valid !== 1'b1 ||
          bus.id_pc !== 32'(4 * i) || bus.id_pc_plus4 !== 32'(4 * i + 4)) begin
        n_err++;
        $display("FAIL fetch_const[%0d]: pc=%h id_instr=%h id_pc=%h id_pc_plus4=%h", i,
                 bus.pc, bus.id_instr, bus.id_pc, bus.id_pc_plus4);
      end
    end
  endtask

  task automatic test_stall();
    obs_t o, e;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0);
      e = sb.pop_front();
      o = sample();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL stall[%0d]: got %h required %h", i, o, e);
      end
      n_vec++;
      if (bus.pc !== 32'h8 || bus.id_instr !== 32'h0030_0113) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: pc=%h id_instr=%h required 8/00300113", i, bus.pc,
                 bus.id_instr);
      end
    end
    step(1'b0, 1'b0, 32'h0);
    e = sb.pop_front();
    o = sample();
    n_vec++;
    if (o !== e || bus.id_instr !== 32'h0020_81b3 || bus.pc !== 32'hC) begin
      n_err++;
      $display("FAIL stall_release: got %h required %h", o, e);
    end
  endtask

  task automatic test_redirect();
    obs_t o, e;
    step(1'b0, 1'b1, 32'h40);
    e = sb.pop_front();
    o = sample();
    n_vec++;
    if (o !== e || bus.pc !== 32'h40 || bus.id_valid !== 1'b0 || bus.id_instr !== 32'h13) begin
      n_err++;
      $display("FAIL redirect_bubble: got %h required %h", o, e);
    end
    step(1'b0, 1'b0, 32'h0);
    e = sb.pop_front();
    o = sample();
    n_vec++;
    if (o !== e || bus.id_instr !== 32'h0000_0537 || bus.id_pc !== 32'h40) begin
      n_err++;
      $display("FAIL redirect_target_fetch: got %h required %h", o, e);
    end
  endtask

  task automatic test_redirect_stall_misaligned();
    obs_t o, e;
    step(1'b1, 1'b1, 32'h42);
    e = sb.pop_front();
    o = sample();
    n_vec++;
    if (o !== e || bus.pc !== 32'h40 || bus.redirect_misaligned !== 1'b1 ||
        bus.id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL misaligned_redirect: got %h required %h", o, e);
    end
    step(1'b1, 1'b0, 32'h0);
    e = sb.pop_front();
    o = sample();
    n_vec++;
    if (o !== e || bus.redirect_misaligned !== 1'b0) begin
      n_err++;
      $display("FAIL misaligned_pulse: got %h required %h", o, e);
    end
    step(1'b0, 1'b0, 32'h0);
    e = sb.pop_front();
    o = sample();
    n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL misaligned_resume: got %h required %h", o, e);
    end
  endtask

  task automatic test_wrap();
    obs_t o, e;
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    e = sb.pop_front();
    o = sample();
    n_vec++;
    if (o !== e || bus.pc !== 32'hFFFF_FFFC || bus.redirect_misaligned !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_redirect: got %h required %h", o, e);
    end
    step(1'b0, 1'b0, 32'h0);
    e = sb.pop_front();
    o = sample();
    n_vec++;
    if (o !== e || bus.pc !== 32'h0 || bus.id_pc !== 32'hFFFF_FFFC ||
        bus.id_pc_plus4 !== 32'h0 || bus.id_instr !== 32'h0000_006F) begin
      n_err++;
      $display("FAIL wrap: got %h required %h", o, e);
    end
    step(1'b0, 1'b0, 32'h0);
    e = sb.pop_front();
    o = sample();
    n_vec++;
    if (o !== e || bus.id_instr !== 32'h0050_0093) begin
      n_err++;
      $display("FAIL wrap_next: got %h required %h", o, e);
    end
  endtask

  task automatic test_reset_midrun();
    obs_t o, e;
    rst_n = 1'b0;
    #2;
    o = sample();
    n_vec++;
    if (o !== RESET_OBS) begin
      n_err++;
      $display("FAIL async_reset: got %h required %h", o, RESET_OBS);
    end
    @(posedge clk);
    #1;
    o = sample();
    n_vec++;
    if (o !== RESET_OBS) begin
      n_err++;
      $display("FAIL reset_hold: got %h required %h", o, RESET_OBS);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0);
      e = sb.pop_front();
      o = sample();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL restart[%0d]: got %h required %h", i, o, e);
      end
    end
    n_vec++;
    if (bus.pc !== 32'hC || bus.id_instr !== 32'h0020_81b3) begin
      n_err++;
      $display("FAIL restart_seq: pc=%h id_instr=%h required C/002081b3", bus.pc, bus.id_instr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0]    = 32'h0050_0093;
    mem[1]    = 32'h0030_0113;
    mem[2]    = 32'h0020_81b3;
    mem[3]    = 32'h00a0_0213;
    mem[16]   = 32'h0000_0537;
    mem[1023] = 32'h0000_006F;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_redirect_stall_misaligned();
    test_wrap();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
